// File: rtl/dma_mc_ctrl.sv
// rtl/dma_mc_ctrl.sv - multi-channel DMA controller with round-robin shared copy engine
module dma_mc_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_req_valid,
  input  logic                  cfg_req_write,
  input  logic [31:0]           cfg_req_addr,
  input  logic [31:0]           cfg_req_wdata,
  output logic                  cfg_resp_valid,
  output logic [31:0]           cfg_resp_rdata,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  irq
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_q [NUM_CH];
  logic [NUM_CH-1:0]     irq_en_q, busy_q, busy_d, done_q, done_d;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q, rdata_d;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wsrc_q, wsrc_d, wdst_q, wdst_d;
  logic [LEN_WIDTH-1:0]  wrem_q, wrem_d;
  logic [CH_W-1:0]       grant_q, grant_d, rr_q, rr_d, arb_idx;
  logic                  arb_found;

  logic [3:0]      ch_raw;
  logic [CH_W-1:0] ch_sel;
  logic [4:0]      off;
  logic            ch_hit, ch_wr, ch_rd, glb_rd, start_ok;

  assign ch_raw   = cfg_req_addr[8:5];
  assign ch_sel   = CH_W'(ch_raw);
  assign off      = cfg_req_addr[4:0];
  assign ch_hit   = cfg_req_valid && (cfg_req_addr[31:9] == '0) && ({28'd0, ch_raw} < 32'(NUM_CH));
  assign ch_wr    = ch_hit && cfg_req_write;
  assign ch_rd    = ch_hit && !cfg_req_write;
  assign glb_rd   = cfg_req_valid && !cfg_req_write && (cfg_req_addr == 32'h200);
  assign start_ok = ch_wr && (off == 5'h0C) && cfg_req_wdata[0] && !busy_q[ch_sel];

  // busy doubles as the pending flag: it is set on START and cleared at FIN
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (ch_wr && (off == 5'h10) && cfg_req_wdata[1]) done_d[ch_sel] = 1'b0;
    if (start_ok) begin
      if (len_q[ch_sel] == '0) begin
        done_d[ch_sel] = 1'b1;
      end else begin
        busy_d[ch_sel] = 1'b1;
        done_d[ch_sel] = 1'b0;
      end
    end
    if (state_q == S_FIN) begin
      busy_d[grant_q] = 1'b0;
      done_d[grant_q] = 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (ch_rd) begin
      case (off)
        5'h00:   rdata_d = 32'(src_q[ch_sel]);
        5'h04:   rdata_d = 32'(dst_q[ch_sel]);
        5'h08:   rdata_d = 32'(len_q[ch_sel]);
        5'h0C:   rdata_d = {30'd0, irq_en_q[ch_sel], 1'b0};
        5'h10:   rdata_d = {30'd0, done_q[ch_sel], busy_q[ch_sel]};
        default: rdata_d = '0;
      endcase
    end else if (glb_rd) begin
      rdata_d[NUM_CH-1:0]  = done_q;
      rdata_d[8 +: NUM_CH] = busy_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        len_q[c] <= '0;
      end
      irq_en_q     <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_valid_q <= cfg_req_valid;
      resp_rdata_q <= rdata_d;
      if (ch_wr) begin
        case (off)
          5'h00: if (!busy_q[ch_sel]) src_q[ch_sel] <= cfg_req_wdata[ADDR_WIDTH-1:0];
          5'h04: if (!busy_q[ch_sel]) dst_q[ch_sel] <= cfg_req_wdata[ADDR_WIDTH-1:0];
          5'h08: if (!busy_q[ch_sel]) len_q[ch_sel] <= cfg_req_wdata[LEN_WIDTH-1:0];
          5'h0C: irq_en_q[ch_sel] <= cfg_req_wdata[1];
          default: ;
        endcase
      end
    end
  end

  // first pending channel at or after rr_q, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!arb_found && busy_q[CH_W'((int'(rr_q) + i) % NUM_CH)]) begin
        arb_found = 1'b1;
        arb_idx   = CH_W'((int'(rr_q) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wsrc_d  = wsrc_q;
    wdst_d  = wdst_q;
    wrem_d  = wrem_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: if (arb_found) begin
        grant_d = arb_idx;
        wsrc_d  = src_q[arb_idx];
        wdst_d  = dst_q[arb_idx];
        wrem_d  = len_q[arb_idx];
        state_d = S_RD;
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        wsrc_d  = wsrc_q + STEP;
        wdst_d  = wdst_q + STEP;
        wrem_d  = wrem_q - LEN_WIDTH'(1);
        state_d = (wrem_q == LEN_WIDTH'(1)) ? S_FIN : S_RD;
      end
      S_FIN: begin
        rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wsrc_q  <= '0;
      wdst_q  <= '0;
      wrem_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      wsrc_q  <= wsrc_d;
      wdst_q  <= wdst_d;
      wrem_q  <= wrem_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // strobes decode the async-reset state so they fall the instant rst_n drops
  assign mem_rd_en      = (state_q == S_RD);
  assign mem_rd_addr    = mem_rd_en ? wsrc_q : '0;
  assign mem_wr_en      = (state_q == S_WR);
  assign mem_wr_addr    = mem_wr_en ? wdst_q : '0;
  assign mem_wr_data    = mem_wr_en ? mem_rd_data : '0;
  assign cfg_resp_valid = resp_valid_q;
  assign cfg_resp_rdata = resp_rdata_q;
  assign irq            = |(done_q & irq_en_q);
endmodule

// File: tb/tb_dma_mc_ctrl.sv
// tb/tb_dma_mc_ctrl.sv - scoreboard bench for dma_mc_ctrl
module tb_dma_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req_valid = 1'b0, cfg_req_write = 1'b0;
  logic [31:0] cfg_req_addr = '0, cfg_req_wdata = '0;
  logic        cfg_resp_valid;
  logic [31:0] cfg_resp_rdata;
  logic        mem_rd_en, mem_wr_en, irq;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [31:0] mem_rd_data = '0;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_e;
  int    n_chk = 0, n_fail = 0;
  bit    mon_en = 1'b0;

  dma_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req_valid(cfg_req_valid), .cfg_req_write(cfg_req_write),
    .cfg_req_addr(cfg_req_addr), .cfg_req_wdata(cfg_req_wdata),
    .cfg_resp_valid(cfg_resp_valid), .cfg_resp_rdata(cfg_resp_rdata),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_1234;
  endfunction

  // memory: data for a read request appears mid-RD cycle and holds through WR
  always @(negedge clk) if (mem_rd_en) mem_rd_data = mem_f(mem_rd_addr);

  always @(negedge clk) begin
    if (mon_en && (mem_rd_en || mem_wr_en)) begin
      n_chk++;
      if (mem_rd_en && mem_wr_en) begin
        n_fail++;
        $display("FAIL strobe_overlap: rd_en=%b wr_en=%b, required only one", mem_rd_en, mem_wr_en);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_traffic: rd_en=%b rd_addr=%h wr_en=%b wr_addr=%h, required no strobe",
                 mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr);
      end else if (mem_rd_en) begin
        if (mem_rd_addr !== exp_q[0].rd) begin
          n_fail++;
          $display("FAIL rd_addr: got %h required %h", mem_rd_addr, exp_q[0].rd);
        end
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_wr_addr !== mon_e.wr || mem_wr_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL write: got addr %h data %h required addr %h data %h",
                   mem_wr_addr, mem_wr_data, mon_e.wr, mon_e.data);
        end
      end
    end
  end

  task automatic push_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] s, d;
      s = src + 32'(4 * i);
      d = dst + 32'(4 * i);
      exp_q.push_back('{rd: s, wr: d, data: mem_f(s)});
    end
  endtask

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    cfg_req_valid = 1'b1; cfg_req_write = 1'b1; cfg_req_addr = a; cfg_req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    cfg_req_valid = 1'b0; cfg_req_write = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    cfg_req_valid = 1'b1; cfg_req_write = 1'b0; cfg_req_addr = a;
    @(posedge clk);
    @(negedge clk);
    cfg_req_valid = 1'b0;
    d = cfg_resp_rdata;
    v = cfg_resp_valid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    n_chk++;
    if ({irq, mem_rd_en, mem_wr_en, cfg_resp_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 0000", {irq, mem_rd_en, mem_wr_en, cfg_resp_valid});
    end
    n_chk++;
    if ({mem_rd_addr, mem_wr_addr, mem_wr_data, cfg_resp_rdata} !== 128'd0) begin
      n_fail++; $display("FAIL reset_buses: got %h %h %h %h required 0", mem_rd_addr, mem_wr_addr, mem_wr_data, cfg_resp_rdata);
    end
    cfg_read(32'h200, d, v);
    n_chk++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_fail++; $display("FAIL reset_global: got valid %b data %h required 1 00000000", v, d);
    end
    @(negedge clk);
    n_chk++;
    if (cfg_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL resp_single_cycle: got %b required 0", cfg_resp_valid);
    end
  endtask

  task automatic test_single();
    logic [31:0] d; logic v; int lat;
    push_xfer(32'h1000, 32'h2000, 4);
    cfg_write(32'h00, 32'h1000);
    cfg_write(32'h04, 32'h2000);
    cfg_write(32'h08, 32'd4);
    cfg_write(32'h0C, 32'h3);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (irq) begin lat = k; break; end
      @(negedge clk);
    end
    n_chk++;
    if (lat != 11) begin n_fail++; $display("FAIL single_latency: got %0d required 11", lat); end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_words_left: got %0d required 0", exp_q.size()); end
    cfg_read(32'h10, d, v);
    n_chk++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL single_status: got %h required 2", d); end
    cfg_write(32'h0C, 32'h0);
    cfg_write(32'h10, 32'h2);
    cfg_read(32'h10, d, v);
    n_chk++;
    if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL single_clear: got %h irq %b required 0 0", d, irq); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d; logic v; int k;
    cfg_write(32'h20, 32'h3100); cfg_write(32'h24, 32'h4100); cfg_write(32'h28, 32'd2);
    cfg_write(32'h40, 32'h3200); cfg_write(32'h44, 32'h4200); cfg_write(32'h48, 32'd2);
    cfg_write(32'h00, 32'h3000); cfg_write(32'h04, 32'h4000); cfg_write(32'h08, 32'd8);
    push_xfer(32'h3000, 32'h4000, 8);
    push_xfer(32'h3100, 32'h4100, 2);
    push_xfer(32'h3200, 32'h4200, 2);
    cfg_write(32'h0C, 32'h1);
    cfg_write(32'h4C, 32'h1);
    cfg_write(32'h2C, 32'h1);
    cfg_write(32'h0C, 32'h1);
    cfg_write(32'h00, 32'hDEAD0000);
    cfg_read(32'h00, d, v);
    n_chk++;
    if (d !== 32'h3000) begin n_fail++; $display("FAIL rr_busy_src: got %h required 00003000", d); end
    cfg_read(32'h10, d, v);
    n_chk++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL rr_busy_status: got %h required 1", d); end
    cfg_read(32'h200, d, v);
    n_chk++;
    if (d !== 32'h0700) begin n_fail++; $display("FAIL rr_global_busy: got %h required 00000700", d); end
    for (k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_timeout: got %0d words left required 0", exp_q.size()); end
    repeat (3) @(negedge clk);
    cfg_read(32'h200, d, v);
    n_chk++;
    if (d !== 32'h0007) begin n_fail++; $display("FAIL rr_global_done: got %h required 00000007", d); end
    cfg_write(32'h10, 32'h2); cfg_write(32'h30, 32'h2); cfg_write(32'h50, 32'h2);
  endtask

  task automatic test_irq();
    logic [31:0] d; logic v; int lat;
    cfg_write(32'h60, 32'h5000); cfg_write(32'h64, 32'h6000); cfg_write(32'h68, 32'd1);
    push_xfer(32'h5000, 32'h6000, 1);
    cfg_write(32'h6C, 32'h3);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (irq) begin lat = k; break; end
      @(negedge clk);
    end
    n_chk++;
    if (lat != 5) begin n_fail++; $display("FAIL irq_latency: got %0d required 5", lat); end
    cfg_write(32'h70, 32'h2);
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b required 0", irq); end
    push_xfer(32'h5000, 32'h6000, 1);
    cfg_write(32'h6C, 32'h3);
    repeat (3) @(negedge clk);
    cfg_write(32'h70, 32'h2);
    cfg_read(32'h70, d, v);
    n_chk++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_set_wins: got status %h irq %b required 2 1", d, irq);
    end
    cfg_write(32'h70, 32'h2);
    cfg_write(32'h6C, 32'h0);
  endtask

  task automatic test_edges();
    logic [31:0] d; logic v; int k;
    cfg_write(32'h28, 32'd0);
    cfg_write(32'h2C, 32'h1);
    cfg_read(32'h30, d, v);
    n_chk++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL len0_status: got %h required 2", d); end
    repeat (4) @(negedge clk);
    cfg_write(32'h30, 32'h2);
    cfg_write(32'h48, 32'h0001_0002);
    cfg_read(32'h48, d, v);
    n_chk++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL len_mask: got %h required 2", d); end
    cfg_write(32'h40, 32'hFFFF_FFFC);
    cfg_write(32'h44, 32'h7000);
    push_xfer(32'hFFFF_FFFC, 32'h7000, 2);
    cfg_write(32'h4C, 32'h1);
    for (k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: got %0d words left required 0", exp_q.size()); end
    repeat (3) @(negedge clk);
    cfg_write(32'h50, 32'h2);
    cfg_write(32'hA0, 32'h1234);
    cfg_read(32'hA0, d, v);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_ch5: got %h required 0", d); end
    cfg_read(32'h14, d, v);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_offset: got %h required 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v; bit found;
    logic [31:0] addrs [5];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h200};
    mon_en = 1'b0;
    cfg_write(32'h00, 32'h8000); cfg_write(32'h04, 32'h9000); cfg_write(32'h08, 32'd8);
    cfg_write(32'h0C, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_wr_en) begin found = 1'b1; break; end
    end
    n_chk++;
    if (!found) begin n_fail++; $display("FAIL mid_no_write: got no wr strobe required one"); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_rd_en, mem_wr_en, irq} !== 3'b0 || mem_wr_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_async_drop: got rd %b wr %b irq %b addr %h required 0", mem_rd_en, mem_wr_en, irq, mem_wr_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    foreach (addrs[i]) begin
      cfg_read(addrs[i], d, v);
      n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL mid_reg_%h: got %h required 0", addrs[i], d); end
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_irq();
    test_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/dma_mc_ctrl.md
Name: dma_mc_ctrl

Overview:
- Multi-channel successor to the single-channel MMIO-programmed DMA.
- NUM_CH independent channel register sets (src, dst, length, control, status) are programmed over the simplified cfg bus.
- One shared copy engine serves pending channels round-robin, one whole transfer per grant, through a single word-wide memory read/write port.
- Provides registered read responses, per-channel write-1-to-clear done flags and a level interrupt.

Parameters:
- NUM_CH, 4, number of channels, 1..8.
- ADDR_WIDTH, 32, byte address width of the memory port and the SRC/DST registers, at most 32.
- DATA_WIDTH, 32, memory word width; the address step per word is DATA_WIDTH/8.
- LEN_WIDTH, 16, width of the transfer length in words, at most 32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_req_valid  in  1  cfg request strobe, single cycle.
- cfg_req_write  in  1  1 = write, 0 = read.
- cfg_req_addr  in  32  cfg byte address.
- cfg_req_wdata  in  32  cfg write data.
- cfg_resp_valid  out  1  response strobe, exactly one cycle after cfg_req_valid.
- cfg_resp_rdata  out  32  read data, 0 for writes and unmapped addresses.
- mem_rd_en  out  1  memory read request.
- mem_rd_addr  out  ADDR_WIDTH  memory read byte address.
- mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_addr  out  ADDR_WIDTH  memory write byte address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- irq  out  1  level interrupt, |(done & irq_en).

Behaviour:
- Register map: channel c occupies base c*0x20.
  - +0x00 SRC.
  - +0x04 DST.
  - +0x08 LEN in words; bits above LEN_WIDTH are ignored.
  - +0x0C CTRL: bit0 START (write 1 to start, reads 0), bit1 IRQ_EN.
  - +0x10 STATUS: bit0 BUSY (read-only), bit1 DONE (write 1 to clear).
  - 0x200 GLOBAL (read-only): bits[NUM_CH-1:0] DONE, bits[8+NUM_CH-1:8] BUSY.
  - Addresses with channel index >= NUM_CH, or any other offset, read 0; writes to them are ignored.
- Reset: all registers, done, busy and the round-robin pointer are 0, state is IDLE. All outputs are 0.
- cfg response: cfg_resp_valid and cfg_resp_rdata are registered. Read data reflects the register state at the request cycle.
- START on an idle channel sets pending and BUSY in the next cycle and clears DONE.
- START on a BUSY channel is ignored. Writes to SRC, DST or LEN of a BUSY channel are ignored; IRQ_EN stays writable.
- LEN=0 START: DONE is set the next cycle, BUSY never rises, no memory traffic.
- Engine FSM:
  - IDLE: if any channel is pending, grant the first pending channel at or after rr_ptr (wrapping). Latch its src, dst and remaining count into working registers. Go to RD.
  - RD: drive mem_rd_en=1 with mem_rd_addr=src for one cycle. Go to WR.
  - WR: drive mem_wr_en=1, mem_wr_addr=dst, mem_wr_data=mem_rd_data. src and dst each advance by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH. remaining decrements by 1. If remaining was 1, go to FIN, otherwise go to RD.
  - FIN: set DONE and clear BUSY and pending of the granted channel. rr_ptr becomes granted+1 mod NUM_CH. Go to IDLE.
- Timing: throughput is 1 word per 2 cycles. Transfer latency from the START write to DONE visible is 2*LEN+3 cycles.
- Channel registers are never modified by the engine; only the working copies advance.
- Simultaneous DONE set by FIN and a W1C on the same cycle: set wins.
- Simultaneous START writes to several channels are not possible (single cfg bus). Pending requests queue and are served in round-robin order.
- Reset asserted mid-transfer: immediate return to reset state. mem_rd_en and mem_wr_en drop asynchronously; the partial transfer is abandoned.
- Only one of mem_rd_en and mem_wr_en is ever high in any cycle.

Test Plan:
- Reset check: after reset release, all outputs are 0. A read of 0x200 returns 0 with cfg_resp_valid one cycle after the request.
- Single transfer: ch0 SRC=0x1000, DST=0x2000, LEN=4, START.
  - Expected: reads from 0x1000, 0x1004, 0x1008, 0x100C; writes of the same data to 0x2000 through 0x200C.
  - DONE set 11 cycles after START; STATUS reads 0x2.
- Round-robin: ch2 then ch1 started back-to-back with LEN=2 while ch0 (LEN=8) is busy.
  - Expected service order: ch0, ch1, ch2.
  - A START to ch0 while busy is ignored; ch0 SRC is unchanged.
- IRQ and clear: ch3 IRQ_EN=1, LEN=1.
  - Expected: irq rises when DONE sets.
  - Writing 0x2 to 0x70 clears DONE and irq the next cycle. W1C coinciding with FIN leaves DONE=1.
- Edge cases: LEN=0 START sets DONE with no memory strobes. SRC=0xFFFFFFFC, LEN=2 wraps the second read to 0x00000000. A read of 0x0A0 (channel 5, NUM_CH=4) returns 0.
- Reset mid-transfer: assert rst_n low during WR of a LEN=8 transfer.
  - Expected: strobes drop immediately, all registers read 0 after release, no further memory traffic.
